// File: rtl/key_hold_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : key_pkg                                                    |
// | Shared timing constants and state encoding for the key-hold          |
// | generator and its matching hold detector, so both ends agree on      |
// | what "short" and "long" mean.                                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package key_pkg;

  // Generator sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } key_state_e;

  // Default timing at a 50 MHz system clock
  localparam int DEF_CNT_W     = 28;
  localparam int DEF_LONG_CYC  = 150_000_000;  // 3.0 s
  localparam int DEF_SHORT_CYC = 25_000_000;   // 0.5 s
  localparam int DEF_GAP_CYC   = 25_000_000;   // 0.5 s
  localparam int DEF_REP_W     = 4;

endpackage
`default_nettype wire

// File: rtl/key_hold_gen_cyc_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cyc_timer                                                  |
// | Free-running up-counter with synchronous clear and a terminal-count  |
// | flag that marks the last cycle of a phase of 'len' cycles.           |
// | Ports   : clk, rst_n (async active-low), clr (restart at 0),         |
// |           len (phase length, >=1), tc (count == len-1)               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module cyc_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic             tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tc = (r_count == (len - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/key_hold_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : key_hold_gen                                               |
// | Generates timed key presses: key_out high for a short or long        |
// | duration, repeated rep_cnt times with low gaps in between.           |
// | Ports   : FPGA_CLK, rst_n (async active-low)                         |
// |           start    - one-cycle request, honoured only when idle      |
// |           long_sel - 1 selects LONG_CYC, 0 selects SHORT_CYC         |
// |           rep_cnt  - number of presses (0 behaves as 1)              |
// |           abort    - cancels a running sequence                      |
// |           key_out  - generated key level (registered)                |
// |           busy     - sequence in progress                            |
// |           f_done   - one-cycle pulse on normal completion            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module key_hold_gen
  import key_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LONG_CYC  = DEF_LONG_CYC,
  parameter int SHORT_CYC = DEF_SHORT_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int REP_W     = DEF_REP_W
) (
  input  logic             FPGA_CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             long_sel,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             key_out,
  output logic             busy,
  output logic             f_done
);

  localparam logic [CNT_W-1:0] C_LONG_LEN  = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] C_SHORT_LEN = CNT_W'(SHORT_CYC);
  localparam logic [CNT_W-1:0] C_GAP_LEN   = CNT_W'(GAP_CYC);

  localparam longint C_MAX_CYC = (longint'(1) << CNT_W) - 1;
  localparam bit C_PARAMS_OK =
    (longint'(LONG_CYC)  >= 1) && (longint'(LONG_CYC)  <= C_MAX_CYC) &&
    (longint'(SHORT_CYC) >= 1) && (longint'(SHORT_CYC) <= C_MAX_CYC) &&
    (longint'(GAP_CYC)   >= 1) && (longint'(GAP_CYC)   <= C_MAX_CYC);

  key_state_e       r_state;
  logic [CNT_W-1:0] r_len;
  logic [REP_W-1:0] r_reps;

  logic [CNT_W-1:0] w_phase_len;
  logic             w_tc;
  logic             w_clr;

  // One timer serves both timed phases; only the length it compares to changes.
  assign w_phase_len = (r_state == GAP) ? C_GAP_LEN : r_len;

  // Restart the count whenever a phase ends or nothing is being timed,
  // so every HOLD/GAP phase begins at count 0.
  assign w_clr = (r_state == IDLE) || (r_state == DONE) || abort || w_tc;

  cyc_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (FPGA_CLK),
    .rst_n (rst_n),
    .clr   (w_clr),
    .len   (w_phase_len),
    .tc    (w_tc)
  );

  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_reps  <= '0;
      key_out <= 1'b0;
      busy    <= 1'b0;
      f_done  <= 1'b0;
    end else begin
      f_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // abort has priority over a simultaneous start
          if (start && !abort) begin
            r_state <= HOLD;
            r_len   <= long_sel ? C_LONG_LEN : C_SHORT_LEN;
            r_reps  <= (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
            key_out <= 1'b1;
            busy    <= 1'b1;
          end
        end

        HOLD: begin
          if (abort) begin
            r_state <= IDLE;
            key_out <= 1'b0;
            busy    <= 1'b0;
          end else if (w_tc) begin
            r_reps  <= r_reps - REP_W'(1);
            key_out <= 1'b0;
            // More than one press left before the decrement means another follows
            if (r_reps > REP_W'(1)) begin
              r_state <= GAP;
            end else begin
              r_state <= DONE;
              f_done  <= 1'b1;
            end
          end
        end

        GAP: begin
          if (abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (w_tc) begin
            r_state <= HOLD;
            key_out <= 1'b1;
          end
        end

        DONE: begin
          // Single completion cycle; abort here changes nothing further
          r_state <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          key_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Phase lengths must fit the counter without wrapping and be non-zero
  a_params_ok : assert property (@(posedge FPGA_CLK) C_PARAMS_OK);
`endif

endmodule
`default_nettype wire
